// File: rtl/calc_result_display.sv
// calc_result_display
//   Captures the Calculator result and flags on a start strobe. A sequential
//   double-dabble engine, one bit per clock, converts the result to packed BCD.
//   The module then drives active-low seven-segment patterns with leading-zero
//   blanking and an overflow dash display.
//
// Ports
//   clock      system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      capture result/flags and convert (honoured only in IDLE)
//   resultado  unsigned result, 2*NBITS bits
//   banderas   flag vector, latched into flags_q on an accepted start
//   busy       high while shifting
//   done       one-cycle pulse when bcd/seg/ovf have just been updated
//   bcd        packed BCD of the last converted value, digit 0 in [3:0]
//   seg        active-low gfedcba patterns, digit 0 in [6:0]
//   flags_q    banderas captured with the last accepted start
//   ovf        last converted value did not fit in DIGITS decimal digits
module calc_result_display #(
  parameter int unsigned NBITS  = 4,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [2*NBITS-1:0]    resultado,
  input  logic [3:0]            banderas,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic [3:0]            flags_q,
  output logic                  ovf
);

  localparam int unsigned W  = 2 * NBITS;
  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned SW = 7 * DIGITS;
  localparam int unsigned CW = $clog2(W + 1);

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegDash  = 7'b0111111;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] Limit = pow10(DIGITS);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    shift_q, val_q;
  logic [BW-1:0]   scratch_q;
  logic [CW-1:0]   cnt_q;
  logic [BW-1:0]   bcd_q;
  logic [SW-1:0]   seg_q;
  logic            ovf_q;

  logic [BW-1:0]   adj;
  logic [BW-1:0]   scratch_nxt;
  logic [W-1:0]    shift_nxt;
  logic            last;
  logic            ovf_nxt;
  logic [SW-1:0]   seg_nxt;
  logic            lead;
  logic [3:0]      dig;

  // Double-dabble step: add 3 to any digit >= 5, then shift scratch:shift left.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    scratch_nxt = {adj[BW-2:0], shift_q[W-1]};
    shift_nxt   = {shift_q[W-2:0], 1'b0};
    last        = (cnt_q == CW'(1));
    // Truncated scratch still yields exact low digits: carries only move upward.
    ovf_nxt     = (64'(val_q) >= Limit);
  end

  // Segment patterns from the final scratch; scan from the top to blank leading zeros.
  always_comb begin
    seg_nxt = '1;
    lead    = 1'b1;
    dig     = 4'd0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      dig = scratch_nxt[4*i +: 4];
      if (dig != 4'd0) lead = 1'b0;
      if (ovf_nxt)                seg_nxt[7*i +: 7] = SegDash;
      else if (lead && (i != 0))  seg_nxt[7*i +: 7] = SegBlank;
      else                        seg_nxt[7*i +: 7] = seg7(dig);
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (last)  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q == StShift);
    done = (state_q == StDone);
    bcd  = bcd_q;
    seg  = seg_q;
    ovf  = ovf_q;
  end

  // Datapath
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q   <= '0;
      val_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      seg_q     <= '1;
      flags_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (state_q == StIdle && start) begin
        shift_q   <= resultado;
        val_q     <= resultado;
        scratch_q <= '0;
        cnt_q     <= CW'(W);
        flags_q   <= banderas;
      end else if (state_q == StShift) begin
        shift_q   <= shift_nxt;
        scratch_q <= scratch_nxt;
        cnt_q     <= cnt_q - CW'(1);
        if (last) begin
          bcd_q <= scratch_nxt;
          seg_q <= seg_nxt;
          ovf_q <= ovf_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_result_display.sv
module tb_calc_result_display;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, start6;
  logic [7:0]  resultado;
  logic [11:0] res6;
  logic [3:0]  banderas, band6;
  logic        busy, done, ovf, busy6, done6, ovf6;
  logic [11:0] bcd, bcd6;
  logic [20:0] seg, seg6;
  logic [3:0]  flags_q, flags6;

  int nvec = 0;
  int nerr = 0;

  calc_result_display #(.NBITS(4), .DIGITS(3)) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .resultado(resultado),
    .banderas(banderas), .busy(busy), .done(done), .bcd(bcd), .seg(seg),
    .flags_q(flags_q), .ovf(ovf)
  );

  calc_result_display #(.NBITS(6), .DIGITS(3)) u_dut6 (
    .clock(clock), .reset_n(reset_n), .start(start6), .resultado(res6),
    .banderas(band6), .busy(busy6), .done(done6), .bcd(bcd6), .seg(seg6),
    .flags_q(flags6), .ovf(ovf6)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start one conversion, wait (bounded) for done; lat = edges after the start edge.
  task automatic conv(input bit sel6, input logic [11:0] v, input logic [3:0] f,
                      output int lat);
    if (sel6) begin res6 = v; band6 = f; start6 = 1'b1; end
    else begin resultado = v[7:0]; banderas = f; start = 1'b1; end
    step();
    start  = 1'b0;
    start6 = 1'b0;
    lat    = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      lat++;
      if ((sel6 ? done6 : done) === 1'b1) break;
    end
  endtask

  int lat, ndone, first_e, prev_e;

  initial begin
    reset_n = 1'b0; start = 1'b0; start6 = 1'b0;
    resultado = '0; res6 = '0; banderas = '0; band6 = '0;
    step(); step();

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'h000);
    check("rst_seg", 32'(seg), 32'h1FFFFF);
    check("rst_flags", 32'(flags_q), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_seg6", 32'(seg6), 32'h1FFFFF);
    reset_n = 1'b1;
    step();

    // Reset mid-conversion
    resultado = 8'd200; banderas = 4'b1001; start = 1'b1;
    step();
    start = 1'b0;
    check("mid_busy_e0", 32'(busy), 32'd1);
    check("mid_flags_e0", 32'(flags_q), 32'b1001);
    step(); step();
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_bcd", 32'(bcd), 32'h000);
    check("mid_rst_seg", 32'(seg), 32'h1FFFFF);
    check("mid_rst_flags", 32'(flags_q), 32'd0);
    step();
    reset_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    check("mid_no_activity", 32'(ndone), 32'd0);

    // Value 9: per-edge busy/done timing
    resultado = 8'd9; banderas = 4'b0000; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("v9_done_e%0d", k), 32'(done), (k == 8) ? 32'd1 : 32'd0);
      check($sformatf("v9_busy_e%0d", k), 32'(busy), (k == 8) ? 32'd0 : 32'd1);
    end
    check("v9_bcd", 32'(bcd), 32'h009);
    check("v9_seg", 32'(seg), 32'({7'h7F, 7'h7F, 7'h10}));
    check("v9_ovf", 32'(ovf), 32'd0);
    step();
    check("v9_done_drop", 32'(done), 32'd0);
    check("v9_bcd_hold", 32'(bcd), 32'h009);

    // Value 45 with flags
    resultado = 8'd45; banderas = 4'b0010; start = 1'b1;
    step();
    start = 1'b0;
    check("v45_flags_e0", 32'(flags_q), 32'b0010);
    check("v45_bcd_held", 32'(bcd), 32'h009);
    lat = 1;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) break;
      step();
      lat++;
    end
    check("v45_lat", 32'(lat), 32'd9);
    check("v45_bcd", 32'(bcd), 32'h045);
    check("v45_seg", 32'(seg), 32'({7'h7F, 7'h19, 7'h12}));
    step();

    // Value 255, inputs changed mid-flight
    resultado = 8'd255; banderas = 4'b0101; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    resultado = 8'd0; banderas = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) break;
      step();
    end
    check("v255_done", 32'(done), 32'd1);
    check("v255_bcd", 32'(bcd), 32'h255);
    check("v255_seg", 32'(seg), 32'({7'h24, 7'h12, 7'h12}));
    check("v255_flags", 32'(flags_q), 32'b0101);
    step();

    // Value 0
    conv(1'b0, 12'd0, 4'b0000, lat);
    check("v0_lat", 32'(lat), 32'd8);
    check("v0_bcd", 32'(bcd), 32'h000);
    check("v0_seg", 32'(seg), 32'({7'h7F, 7'h7F, 7'h40}));
    step();

    // start held high: SHIFT(8) + DONE + IDLE accept -> one result every 10 edges
    resultado = 8'd100; start = 1'b1;
    ndone = 0; first_e = -1; prev_e = -1;
    for (int e = 0; e < 30; e++) begin
      step();
      if (done === 1'b1) begin
        ndone++;
        check("held_bcd", 32'(bcd), 32'h100);
        if (prev_e < 0) first_e = e;
        else check("held_period", 32'(e - prev_e), 32'd10);
        prev_e = e;
      end
    end
    start = 1'b0;
    check("held_first", 32'(first_e), 32'd8);
    check("held_count", 32'(ndone), 32'd3);
    step(); step();

    // 12-bit instance: overflow and largest in-range value
    conv(1'b1, 12'd1000, 4'b0011, lat);
    check("w12_1000_lat", 32'(lat), 32'd12);
    check("w12_1000_ovf", 32'(ovf6), 32'd1);
    check("w12_1000_bcd", 32'(bcd6), 32'h000);
    check("w12_1000_seg", 32'(seg6), 32'({7'h3F, 7'h3F, 7'h3F}));
    check("w12_flags", 32'(flags6), 32'b0011);
    step();
    conv(1'b1, 12'd999, 4'b0000, lat);
    check("w12_999_lat", 32'(lat), 32'd12);
    check("w12_999_ovf", 32'(ovf6), 32'd0);
    check("w12_999_bcd", 32'(bcd6), 32'h999);
    check("w12_999_seg", 32'(seg6), 32'({7'h10, 7'h10, 7'h10}));
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
